// File: rtl/cave_video_pkg.sv
// Shared video definitions for the frame pixel packer: default widths, the
// output-register FSM state type and the padding helper used on word completion.
package cave_video_pkg;

   localparam int PIXEL_WIDTH_DEF     = 16;
   localparam int WORD_WIDTH_DEF      = 64;
   localparam int PIXELS_PER_WORD_DEF = WORD_WIDTH_DEF / PIXEL_WIDTH_DEF;

   typedef enum logic {
      FILL      = 1'b0,
      HOLD_FULL = 1'b1
   } packer_state_t;

   // Slots whose mask bit is clear were never written for this line and get the pad pixel.
   function automatic logic [WORD_WIDTH_DEF-1:0] pad_word(
      input logic [WORD_WIDTH_DEF-1:0]      acc,
      input logic [PIXELS_PER_WORD_DEF-1:0] slot_mask,
      input logic [PIXEL_WIDTH_DEF-1:0]     pad_value
   );
      logic [WORD_WIDTH_DEF-1:0] word;
      word = acc;
      for (int i = 0; i < PIXELS_PER_WORD_DEF; i++) begin
         if (!slot_mask[i]) word[i*PIXEL_WIDTH_DEF +: PIXEL_WIDTH_DEF] = pad_value;
      end
      return word;
   endfunction

endpackage

// File: rtl/frame_pixel_packer_if.sv
// Pixel-in / word-out bus of the frame pixel packer. The io_overflow member
// exists only when PACKER_OVERFLOW_DETECT_EN is defined.
interface frame_pixel_packer_if #(
   parameter int PIXEL_WIDTH = 16,
   parameter int WORD_WIDTH  = 64
);
   logic                   io_in_valid;
   logic [PIXEL_WIDTH-1:0] io_in_bits;
   logic                   io_in_last;
   logic                   io_out_valid;
   logic                   io_out_ready;
   logic [WORD_WIDTH-1:0]  io_out_bits;
   logic                   io_out_last;
   logic                   io_busy;
`ifdef PACKER_OVERFLOW_DETECT_EN
   logic                   io_overflow;

   // master is the packer itself; slave is the pixel source plus FIFO side.
   modport master (
      input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
      output io_out_valid, io_out_bits, io_out_last, io_busy, io_overflow
   );
   modport slave (
      output io_in_valid, io_in_bits, io_in_last, io_out_ready,
      input  io_out_valid, io_out_bits, io_out_last, io_busy, io_overflow
   );
`else
   modport master (
      input  io_in_valid, io_in_bits, io_in_last, io_out_ready,
      output io_out_valid, io_out_bits, io_out_last, io_busy
   );
   modport slave (
      output io_in_valid, io_in_bits, io_in_last, io_out_ready,
      input  io_out_valid, io_out_bits, io_out_last, io_busy
   );
`endif
endinterface

// File: rtl/packer_out_reg.sv
// Single-entry valid/ready holding register. A load arriving while the held
// entry transfers replaces it without a bubble; a load while stalled is ignored.
module packer_out_reg
   import cave_video_pkg::*;
#(
   parameter int WIDTH = WORD_WIDTH_DEF + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [WIDTH-1:0] load_data,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data
);

   packer_state_t state;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clock) begin
      if (reset) begin
         state     <= FILL;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         case (state)
            FILL: begin
               if (load_valid) begin
                  state     <= HOLD_FULL;
                  out_valid <= 1'b1;
                  out_data  <= load_data;
               end
            end
            HOLD_FULL: begin
               if (out_ready) begin
                  if (load_valid) begin
                     out_data <= load_data;
                  end else begin
                     state     <= FILL;
                     out_valid <= 1'b0;
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/frame_pixel_packer.sv
// Packs fixed-width pixels into words for the frame FIFO; line-end flushes a padded
// partial word. Define PACKER_OVERFLOW_DETECT_EN for the sticky io_overflow flag.
module frame_pixel_packer
   import cave_video_pkg::*;
#(
   parameter int                     PIXEL_WIDTH = PIXEL_WIDTH_DEF,
   parameter int                     WORD_WIDTH  = WORD_WIDTH_DEF,
   parameter logic [PIXEL_WIDTH-1:0] PAD_VALUE   = '0
) (
   input logic                  clock,
   input logic                  reset,
   frame_pixel_packer_if.master io
);

   localparam int PIXELS_PER_WORD = WORD_WIDTH / PIXEL_WIDTH;
   localparam int CNT_W           = $clog2(PIXELS_PER_WORD);

   logic [CNT_W-1:0]           count;
   logic [WORD_WIDTH-1:0]      acc;
   logic [WORD_WIDTH-1:0]      acc_next;
   logic [WORD_WIDTH-1:0]      word;
   logic [PIXELS_PER_WORD-1:0] slot_valid;
   logic [PIXELS_PER_WORD-1:0] mask_next;
   logic                       complete;
   logic                       out_valid;
   logic [WORD_WIDTH:0]        out_data;

   // NOTE: default assignment first so the partial update cannot infer a latch.
   always_comb begin
      acc_next = acc;
      acc_next[count*PIXEL_WIDTH +: PIXEL_WIDTH] = io.io_in_bits;
   end

   assign mask_next = slot_valid | (PIXELS_PER_WORD'(1) << count);
   assign complete  = io.io_in_valid & ((count == CNT_W'(PIXELS_PER_WORD - 1)) | io.io_in_last);
   assign word      = pad_word(acc_next, mask_next, PAD_VALUE);

   always_ff @(posedge clock) begin
      if (reset) begin
         count      <= '0;
         acc        <= '0;
         slot_valid <= '0;
      end else if (io.io_in_valid) begin
         if (complete) begin
            count      <= '0;
            acc        <= '0;
            slot_valid <= '0;
         end else begin
            count      <= count + CNT_W'(1);
            acc        <= acc_next;
            slot_valid <= mask_next;
         end
      end
   end

   // The accumulator restarts on completion even when the output register drops the word.
   packer_out_reg #(.WIDTH(WORD_WIDTH + 1)) u_out_reg (
      .clock      (clock),
      .reset      (reset),
      .load_valid (complete),
      .load_data  ({io.io_in_last, word}),
      .out_ready  (io.io_out_ready),
      .out_valid  (out_valid),
      .out_data   (out_data)
   );

   assign io.io_out_valid = out_valid;
   assign io.io_out_last  = out_data[WORD_WIDTH];
   assign io.io_out_bits  = out_data[WORD_WIDTH-1:0];
   assign io.io_busy      = (count != '0) | out_valid;

`ifdef PACKER_OVERFLOW_DETECT_EN
   logic        drop;
   logic [15:0] drop_count;

   assign drop = complete & out_valid & ~io.io_out_ready;

   always_ff @(posedge clock) begin
      if (reset) begin
         drop_count <= '0;
      end else if (drop && drop_count != 16'hFFFF) begin
         drop_count <= drop_count + 16'd1;
      end
   end

   // Saturating counter never wraps back to zero, so non-zero is the sticky flag.
   assign io.io_overflow = (drop_count != '0);
`endif

endmodule

// File: tb/tb_frame_pixel_packer.sv
// Self-checking bench for frame_pixel_packer: directed vector table, hand-written
// corner sequences, and randomized traffic against a queue-based reference model.
module tb_frame_pixel_packer;

   logic clock;
   logic reset;

   frame_pixel_packer_if #(.PIXEL_WIDTH(16), .WORD_WIDTH(64)) bus ();

   frame_pixel_packer dut (
      .clock (clock),
      .reset (reset),
      .io    (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int total;
   int bad;

   typedef struct {
      logic        v;
      logic [15:0] b;
      logic        l;
      logic        r;
      logic        ev;
      logic [63:0] eb;
      logic        el;
      logic        ebusy;
   } vec_t;

   vec_t vecs[13];

   // Reference model: pixels of the current word sit in a queue; one held output word.
   logic [15:0] m_pend[$];
   bit          m_valid;
   logic [63:0] m_word;
   bit          m_last;
   int          m_drops;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pend.delete();
      m_valid = 0;
      m_word  = '0;
      m_last  = 0;
      m_drops = 0;
   endtask

   task automatic model_step(input logic v, input logic [15:0] b, input logic l, input logic r);
      logic [63:0] w;
      if (m_valid && r) m_valid = 0;
      if (v) begin
         m_pend.push_back(b);
         if (m_pend.size() == 4 || l) begin
            w = '0;
            for (int i = 0; i < m_pend.size(); i++) w = w | (64'(m_pend[i]) << (16 * i));
            m_pend.delete();
            if (m_valid) m_drops++;
            else begin
               m_valid = 1;
               m_word  = w;
               m_last  = l;
            end
         end
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, " valid"}, 64'(bus.io_out_valid), 64'(m_valid));
      if (m_valid) begin
         check({tag, " bits"}, bus.io_out_bits, m_word);
         check({tag, " last"}, 64'(bus.io_out_last), 64'(m_last));
      end
      check({tag, " busy"}, 64'(bus.io_busy), 64'((m_pend.size() != 0) || m_valid));
`ifdef PACKER_OVERFLOW_DETECT_EN
      check({tag, " overflow"}, 64'(bus.io_overflow), 64'(m_drops != 0));
`endif
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cycle(input logic v, input logic [15:0] b, input logic l, input logic r);
      bus.io_in_valid  = v;
      bus.io_in_bits   = b;
      bus.io_in_last   = l;
      bus.io_out_ready = r;
      model_step(v, b, l, r);
      tick();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.io_in_valid  = 1'b0;
      bus.io_in_bits   = '0;
      bus.io_in_last   = 1'b0;
      bus.io_out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      model_reset();
   endtask

   function automatic logic [15:0] pix(input int i);
      return 16'((i * 16'h0101) + 7);
   endfunction

   initial begin
      logic [63:0] got[$];
      logic [63:0] exp_w;

      total = 0;
      bad   = 0;

      vecs[0]  = '{1'b1, 16'h1111, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[1]  = '{1'b1, 16'h2222, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[2]  = '{1'b1, 16'h3333, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[3]  = '{1'b1, 16'h4444, 1'b0, 1'b1, 1'b1, 64'h4444_3333_2222_1111, 1'b0, 1'b1};
      vecs[4]  = '{1'b1, 16'hAAAA, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[5]  = '{1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b1, 64'h0000_0000_BBBB_AAAA, 1'b1, 1'b1};
      vecs[6]  = '{1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 64'h0000_0000_BBBB_AAAA, 1'b1, 1'b1};
      vecs[7]  = '{1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[8]  = '{1'b1, 16'h6666, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[9]  = '{1'b1, 16'h7777, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1};
      vecs[10] = '{1'b1, 16'h8888, 1'b0, 1'b1, 1'b1, 64'h8888_7777_6666_5555, 1'b0, 1'b1};
      vecs[11] = '{1'b1, 16'h9999, 1'b1, 1'b1, 1'b1, 64'h0000_0000_0000_9999, 1'b1, 1'b1};
      vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0};

      do_reset();
      check("reset valid", 64'(bus.io_out_valid), 64'(0));
      check("reset bits", bus.io_out_bits, 64'h0);
      check("reset last", 64'(bus.io_out_last), 64'(0));
      check("reset busy", 64'(bus.io_busy), 64'(0));
`ifdef PACKER_OVERFLOW_DETECT_EN
      check("reset overflow", 64'(bus.io_overflow), 64'(0));
`endif

      // Directed table: full word, short line, stall, slot-0 restart, single-pixel replace.
      for (int i = 0; i < 13; i++) begin
         cycle(vecs[i].v, vecs[i].b, vecs[i].l, vecs[i].r);
         check($sformatf("vec%0d valid", i), 64'(bus.io_out_valid), 64'(vecs[i].ev));
         if (vecs[i].ev) begin
            check($sformatf("vec%0d bits", i), bus.io_out_bits, vecs[i].eb);
            check($sformatf("vec%0d last", i), 64'(bus.io_out_last), 64'(vecs[i].el));
         end
         check($sformatf("vec%0d busy", i), 64'(bus.io_busy), 64'(vecs[i].ebusy));
      end

      // Stalled output, 8 pixels: first word held, second dropped.
      do_reset();
      for (int i = 1; i <= 8; i++) cycle(1'b1, 16'(i), 1'b0, 1'b0);
      check("stall valid", 64'(bus.io_out_valid), 64'(1));
      check("stall bits", bus.io_out_bits, 64'h0004_0003_0002_0001);
      check("stall busy", 64'(bus.io_busy), 64'(1));
`ifdef PACKER_OVERFLOW_DETECT_EN
      check("stall overflow", 64'(bus.io_overflow), 64'(1));
`endif
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("stall drain valid", 64'(bus.io_out_valid), 64'(0));
      check("stall drain busy", 64'(bus.io_busy), 64'(0));
`ifdef PACKER_OVERFLOW_DETECT_EN
      check("stall overflow sticky", 64'(bus.io_overflow), 64'(1));
`endif

      // Reset mid-word with a held word: both discarded, next word starts at slot 0.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
      cycle(1'b1, 16'h0010, 1'b0, 1'b0);
      cycle(1'b1, 16'h0020, 1'b0, 1'b0);
      do_reset();
      check("midreset valid", 64'(bus.io_out_valid), 64'(0));
      check("midreset busy", 64'(bus.io_busy), 64'(0));
`ifdef PACKER_OVERFLOW_DETECT_EN
      check("midreset overflow", 64'(bus.io_overflow), 64'(0));
`endif
      cycle(1'b1, 16'h0010, 1'b0, 1'b1);
      cycle(1'b1, 16'h0020, 1'b0, 1'b1);
      cycle(1'b1, 16'h0030, 1'b0, 1'b1);
      cycle(1'b1, 16'h0040, 1'b0, 1'b1);
      check("midreset word valid", 64'(bus.io_out_valid), 64'(1));
      check("midreset word bits", bus.io_out_bits, 64'h0040_0030_0020_0010);

      // Continuous streaming: 64 pixels, always ready, expect 16 ordered words.
      do_reset();
      got.delete();
      for (int i = 0; i < 64; i++) begin
         cycle(1'b1, pix(i), 1'b0, 1'b1);
         check_model($sformatf("stream%0d", i));
         if (bus.io_out_valid) got.push_back(bus.io_out_bits);
      end
      cycle(1'b0, 16'h0, 1'b0, 1'b1);
      check("stream idle valid", 64'(bus.io_out_valid), 64'(0));
      check("stream word count", 64'(got.size()), 64'(16));
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         exp_w = '0;
         for (int j = 0; j < 4; j++) exp_w = exp_w | (64'(pix(4 * k + j)) << (16 * j));
         check($sformatf("stream word%0d", k), got[k], exp_w);
      end
`ifdef PACKER_OVERFLOW_DETECT_EN
      check("stream overflow", 64'(bus.io_overflow), 64'(0));
`endif

      // Randomized traffic against the reference model.
      do_reset();
      for (int i = 0; i < 1500; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 1)));
         check_model($sformatf("rand%0d", i));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
